// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back stage and architectural register file of the
// single-issue RV32I core.
//
// Commits load results (memory stage) and ALU results (execute stage) through
// a single register-file write port. When both sources present an effective
// write in the same cycle, the load commits first. The exec result is parked
// in a one-entry pending buffer and drained on the following edge, while
// wb_stall holds upstream. The register snapshot overlays the pending buffer,
// so consumers always see the newest value.
//
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire_count port, which
// counts register-file writes that land at an edge (x0 writes excluded).
//
// Ports:
//   clk            core clock; all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   load_active    memory stage presents a load result
//   load_rd        load destination index
//   load_rd_value  load data (already extended)
//   exec_valid     execute stage presents an ALU result
//   exec_rd        ALU destination index
//   exec_rd_value  ALU result
//   general_reg    register snapshot, index i at [i*BIN_DIG +: BIN_DIG]
//   wb_stall       upstream must hold its outputs and not advance
//   retire_count   committed-write counter (WB_RETIRE_CNT_EN only)
module writeback_regfile #(
  parameter int BIN_DIG = 32,
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_active,
  input  logic [REG_AW-1:0]          load_rd,
  input  logic [BIN_DIG-1:0]         load_rd_value,
  input  logic                       exec_valid,
  input  logic [REG_AW-1:0]          exec_rd,
  input  logic [BIN_DIG-1:0]         exec_rd_value,
  output logic [REG_NUM*BIN_DIG-1:0] general_reg,
  output logic                       wb_stall
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]                retire_count
`endif
);

  // IDLE: pending buffer empty. DRAIN: buffer holds the younger exec result.
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state, state_nx;
  logic [BIN_DIG-1:0] regs [REG_NUM];
  logic [REG_AW-1:0]  pend_rd;
  logic [BIN_DIG-1:0] pend_value;

  logic               load_eff, exec_eff;
  logic               wr_en, cap_en;
  logic [REG_AW-1:0]  wr_rd;
  logic [BIN_DIG-1:0] wr_value;

  assign load_eff = load_active && (load_rd != '0);
  assign exec_eff = exec_valid  && (exec_rd != '0);

  // Single write port select. Inputs are only looked at in IDLE; in DRAIN the
  // buffer owns the port and upstream is stalled.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    cap_en   = 1'b0;
    wr_rd    = '0;
    wr_value = '0;
    case (state)
      IDLE: begin
        if (load_eff) begin
          wr_en    = 1'b1;
          wr_rd    = load_rd;
          wr_value = load_rd_value;
          // The exec result is younger; deferring it keeps program order,
          // so a same-rd collision ends with the exec value.
          if (exec_eff) begin
            cap_en   = 1'b1;
            state_nx = DRAIN;
          end
        end else if (exec_eff) begin
          wr_en    = 1'b1;
          wr_rd    = exec_rd;
          wr_value = exec_rd_value;
        end
      end
      DRAIN: begin
        wr_en    = 1'b1;
        wr_rd    = pend_rd;
        wr_value = pend_value;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_rd    <= '0;
      pend_value <= '0;
    end else begin
      state <= state_nx;
      if (cap_en) begin
        pend_rd    <= exec_rd;
        pend_value <= exec_rd_value;
      end
    end
  end

  // wr_rd is never zero when wr_en is set, so regs[0] stays at its reset 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_rd] <= wr_value;
    end
  end

  // Snapshot with the pending entry overlaid on its destination.
  always_comb begin
    general_reg = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (state == DRAIN && pend_rd == REG_AW'(i)) begin
        general_reg[i*BIN_DIG +: BIN_DIG] = pend_value;
      end else begin
        general_reg[i*BIN_DIG +: BIN_DIG] = regs[i];
      end
    end
  end

  assign wb_stall = (state == DRAIN);

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (wr_en) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile. A reference register model is
// updated as each step is driven; the expected snapshot, stall and retire
// count are queued, then popped and compared after the clock edge.
module tb_writeback_regfile;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_active = 1'b0;
  logic [4:0]    load_rd = '0;
  logic [31:0]   load_rd_value = '0;
  logic          exec_valid = 1'b0;
  logic [4:0]    exec_rd = '0;
  logic [31:0]   exec_rd_value = '0;
  logic [1023:0] general_reg;
  logic          wb_stall;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]   retire_count;
`endif

  writeback_regfile #(.BIN_DIG(32), .REG_NUM(32), .REG_AW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_active   (load_active),
    .load_rd       (load_rd),
    .load_rd_value (load_rd_value),
    .exec_valid    (exec_valid),
    .exec_rd       (exec_rd),
    .exec_rd_value (exec_rd_value),
    .general_reg   (general_reg),
    .wb_stall      (wb_stall)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count  (retire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1023:0] snap;
    logic          stall;
    logic [31:0]   ret;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [32];
  logic        m_stall;
  logic [31:0] m_ret;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [1023:0] mdl_snap();
    logic [1023:0] s;
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = mdl[i];
    return s;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    m_stall = 1'b0;
    m_ret   = '0;
  endtask

  // Compare the oldest queued expectation against the current outputs.
  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_x%0d", tag, i), general_reg[i*32 +: 32], e.snap[i*32 +: 32]);
    chk({tag, "_stall"}, {31'd0, wb_stall}, {31'd0, e.stall});
`ifdef WB_RETIRE_CNT_EN
    chk({tag, "_retire"}, retire_count, e.ret);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, queue expectation, clock,
  // then compare. Called shortly after a rising edge.
  task automatic step(input string tag,
                      input logic la, input logic [4:0] lrd, input logic [31:0] lv,
                      input logic ev, input logic [4:0] erd, input logic [31:0] evv);
    logic le, ee;
    exp_t e;
    load_active = la; load_rd = lrd; load_rd_value = lv;
    exec_valid  = ev; exec_rd = erd; exec_rd_value = evv;
    le = la && (lrd != 5'd0);
    ee = ev && (erd != 5'd0);
    if (m_stall) begin
      m_stall = 1'b0;       // buffered write lands; inputs ignored
      m_ret   = m_ret + 32'd1;
    end else begin
      if (le) begin mdl[lrd] = lv;  m_ret = m_ret + 32'd1; end
      if (ee) begin mdl[erd] = evv; if (!le) m_ret = m_ret + 32'd1; end
      m_stall = le && ee;
    end
    e.snap = mdl_snap(); e.stall = m_stall; e.ret = m_ret;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check_out(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic async_reset_check(input string tag);
    exp_t e;
    rst_n = 1'b0;
    mdl_clear();
    e.snap = mdl_snap(); e.stall = 1'b0; e.ret = '0;
    exp_q.push_back(e);
    #1;
    check_out(tag);
  endtask

  initial begin
    mdl_clear();
    // Reset state
    #3;
    async_reset_check("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single sources
    step("exec_x5",  1'b0, 5'd0, 32'd0,        1'b1, 5'd5, 32'h0000_1234);
    step("load_x6",  1'b1, 5'd6, 32'hFFFF_FF80, 1'b0, 5'd0, 32'd0);

    // Collision, different rd; stall-cycle inputs must be ignored
    step("coll_34",  1'b1, 5'd3, 32'h0000_000A, 1'b1, 5'd4, 32'h0000_000B);
    step("stall_ign",1'b1, 5'd3, 32'h0000_FFFF, 1'b1, 5'd8, 32'h0000_0077);
    idle_step("post_coll");

    // Same-rd collision: exec value wins on both cycles
    step("same_rd7", 1'b1, 5'd7, 32'h0000_0001, 1'b1, 5'd7, 32'h0000_0002);
    idle_step("same_rd7_drain");

    // x0 handling
    step("ld0_ex9",  1'b1, 5'd0, 32'h1111_1111, 1'b1, 5'd9, 32'h0000_0055);
    step("ex0",      1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 32'h0000_DEAD);
    step("ld_x31",   1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);

    // Back-to-back collisions alternate stall cycles
    step("b2b_a",    1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd13, 32'h0000_0D0D);
    step("b2b_a_dr", 1'b1, 5'd14, 32'h0000_0E0E, 1'b1, 5'd15, 32'h0000_0F0F);
    step("b2b_b",    1'b1, 5'd14, 32'h0000_0E0E, 1'b1, 5'd15, 32'h0000_0F0F);
    idle_step("b2b_b_dr");

    // Reset during DRAIN discards the buffered write
    step("coll_rst", 1'b1, 5'd10, 32'h0000_0010, 1'b1, 5'd11, 32'h0000_0099);
    load_active = 1'b0; exec_valid = 1'b0;
    #2;
    async_reset_check("rst_in_drain");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_x11", general_reg[11*32 +: 32], 32'd0);
    chk("post_rst_stall", {31'd0, wb_stall}, 32'd0);
    step("after_rst", 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_0042);
    idle_step("final");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
